lora_alert_scheduler: RTL and testbench

- Sequences voice-prompt playback for alert events received over the LoRa UART link on the home board.
- Decodes received bytes 0x01 (smoke), 0x02 (vibration) and 0x03 (doorbell) into pending-alert bits.
- Arbitrates between pending alerts by fixed priority and drives a one-shot start request to the voice playback module.
- Repeats each prompt with a gap until the user acknowledges it or the repeat limit is reached.

---
 rtl/lora_alert_pkg.sv | 45 ++++
 rtl/lora_alert_latch.sv | 35 +++
 rtl/lora_alert_scheduler.sv | 136 +++++++++++++
 tb/tb_lora_alert_scheduler.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lora_alert_pkg.sv
// Alert ids, LoRa byte codes and FSM state encoding
// shared by the alert scheduler and its pending latch.
package lora_alert_pkg;

   localparam logic [1:0] ID_NONE  = 2'b00;
   localparam logic [1:0] ID_SMOKE = 2'b01;
   localparam logic [1:0] ID_VIB   = 2'b10;
   localparam logic [1:0] ID_DOOR  = 2'b11;

   localparam logic [7:0] BYTE_SMOKE = 8'h01;
   localparam logic [7:0] BYTE_VIB   = 8'h02;
   localparam logic [7:0] BYTE_DOOR  = 8'h03;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WAIT_BUSY,
      S_PLAYING,
      S_GAP
   } state_t;

   function automatic logic [2:0] id_mask(input logic [1:0] id);
      logic [2:0] m;
      case (id)
         ID_SMOKE: m = 3'b001;
         ID_VIB:   m = 3'b010;
         ID_DOOR:  m = 3'b100;
         default:  m = 3'b000;
      endcase
      return m;
   endfunction

   // Fixed priority: smoke > vibration > doorbell
   function automatic logic [1:0] pick(input logic [2:0] pend);
      logic [1:0] id;
      priority case (1'b1)
         pend[0]: id = ID_SMOKE;
         pend[1]: id = ID_VIB;
         pend[2]: id = ID_DOOR;
         default: id = ID_NONE;
      endcase
      return id;
   endfunction

endpackage

// File: rtl/lora_alert_latch.sv
// Decodes LoRa alert bytes into pending bits;
// a set in the same cycle as a clear wins.
module lora_alert_latch
   import lora_alert_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_byte,
   input  logic       rx_valid,
   input  logic [2:0] clr,
   output logic [2:0] pending
);

   logic [2:0] set;

   always_comb begin
      set = 3'b000;
      if (rx_valid) begin
         case (rx_byte)
            BYTE_SMOKE: set = 3'b001;
            BYTE_VIB:   set = 3'b010;
            BYTE_DOOR:  set = 3'b100;
            default:    set = 3'b000;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pending <= 3'b000;
      else
         pending <= (pending & ~clr) | set;
   end

endmodule

// File: rtl/lora_alert_scheduler.sv
// Arbitrates pending LoRa alerts and sequences voice
// prompts with repeat gaps, timeout and acknowledge.
module lora_alert_scheduler
   import lora_alert_pkg::*;
#(
   parameter int GAP_CYCLES  = 50_000_000,
   parameter int BUSY_TO     = 1_000_000,
   parameter int MAX_REPEATS = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_byte,
   input  logic       rx_valid,
   input  logic       ack,
   input  logic       play_busy,
   output logic       play_req,
   output logic [1:0] play_id,
   output logic       alert_active,
   output logic [2:0] pending
);

   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam int BW = $clog2(BUSY_TO + 1);
   localparam int RW = $clog2(MAX_REPEATS + 1);

   localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
   localparam logic [GW-1:0] GAP_MAX   = GW'(GAP_CYCLES);
   localparam logic [BW-1:0] BUSY_LAST = BW'(BUSY_TO - 1);
   localparam logic [BW-1:0] BUSY_MAX  = BW'(BUSY_TO);
   localparam logic [RW-1:0] REP_MAX   = RW'(MAX_REPEATS);

   state_t        state;
   state_t        state_nxt;
   logic [1:0]    cur;
   logic [1:0]    sel;
   logic [RW-1:0] rep_cnt;
   logic [RW-1:0] rep_inc;
   logic [GW-1:0] gap_cnt;
   logic [BW-1:0] wait_cnt;
   logic [2:0]    clr;
   logic          gap_done;
   logic          ack_clr;
   logic          auto_clr;
   logic          latch;

   lora_alert_latch u_latch (
      .clk      (clk),
      .rst      (rst),
      .rx_byte  (rx_byte),
      .rx_valid (rx_valid),
      .clr      (clr),
      .pending  (pending)
   );

   assign sel      = pick(pending);
   assign latch    = (state == S_IDLE) && (pending != 3'b000);
   assign gap_done = (state == S_GAP) && (gap_cnt >= GAP_LAST);
   assign rep_inc  = (rep_cnt == REP_MAX) ? REP_MAX
                                          : rep_cnt + RW'(1);
   assign ack_clr  = ack && (state != S_IDLE);
   // Smoke keeps replaying until acknowledged
   assign auto_clr = gap_done && (rep_inc == REP_MAX)
                     && (cur != ID_SMOKE);
   assign clr      = (ack_clr || auto_clr) ? id_mask(cur) : 3'b000;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:
            if (pending != 3'b000) state_nxt = S_START;
         S_START:
            state_nxt = S_WAIT_BUSY;
         S_WAIT_BUSY:
            if (play_busy)
               state_nxt = S_PLAYING;
            else if (wait_cnt >= BUSY_LAST)
               state_nxt = S_GAP;
         S_PLAYING:
            if (!play_busy) state_nxt = S_GAP;
         S_GAP:
            if (gap_done) state_nxt = S_IDLE;
         default:
            state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      play_req     = 1'b0;
      play_id      = ID_NONE;
      alert_active = 1'b0;
      if (state != S_IDLE) begin
         play_id      = cur;
         alert_active = 1'b1;
      end
      if (state == S_START) play_req = 1'b1;
   end

   // wait_cnt counts cycles since play_req; both timers saturate
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur      <= ID_NONE;
         rep_cnt  <= '0;
         gap_cnt  <= '0;
         wait_cnt <= '0;
      end else begin
         if (latch) cur <= sel;

         if (state == S_GAP) begin
            if (gap_cnt != GAP_MAX) gap_cnt <= gap_cnt + GW'(1);
         end else begin
            gap_cnt <= '0;
         end

         if (state == S_START || state == S_WAIT_BUSY) begin
            if (wait_cnt != BUSY_MAX) wait_cnt <= wait_cnt + BW'(1);
         end else begin
            wait_cnt <= '0;
         end

         if (ack_clr || auto_clr)
            rep_cnt <= '0;
         else if (latch && sel != cur)
            rep_cnt <= '0;
         else if (gap_done)
            rep_cnt <= rep_inc;
      end
   end

endmodule

// File: tb/tb_lora_alert_scheduler.sv
// Bench for lora_alert_scheduler: directed scenarios and
// randomized traffic against a timeline reference model.
module tb_lora_alert_scheduler;

   localparam int GAP  = 8;
   localparam int BTO  = 5;
   localparam int MAXR = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] rx_byte = 8'h00;
   logic       rx_valid = 1'b0;
   logic       ack = 1'b0;
   logic       play_busy = 1'b0;
   logic       play_req;
   logic [1:0] play_id;
   logic       alert_active;
   logic [2:0] pending;

   int n_chk = 0;
   int n_fail = 0;

   lora_alert_scheduler #(
      .GAP_CYCLES  (GAP),
      .BUSY_TO     (BTO),
      .MAX_REPEATS (MAXR)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .rx_byte      (rx_byte),
      .rx_valid     (rx_valid),
      .ack          (ack),
      .play_busy    (play_busy),
      .play_req     (play_req),
      .play_id      (play_id),
      .alert_active (alert_active),
      .pending      (pending)
   );

   always #5 clk = ~clk;

   // Reference model: a prompt is a timeline of absolute cycle
   // stamps (request, gap start) rather than a state machine.
   int       m_t = 0;
   bit       m_act = 0;
   bit       m_seen = 0;
   int       m_req_t = -1;
   int       m_gap_t = -1;
   int       m_cur = 0;
   int       m_reps = 0;
   bit [2:0] m_pend = 0;
   bit [2:0] m_set;
   bit [2:0] m_clr;
   int       m_b;
   logic       exp_req = 0;
   logic [1:0] exp_id = 0;
   logic       exp_alert = 0;
   logic [2:0] exp_pend = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_t = 0; m_act = 0; m_seen = 0;
         m_req_t = -1; m_gap_t = -1;
         m_cur = 0; m_reps = 0; m_pend = 0;
      end else begin
         m_set = 0;
         m_clr = 0;
         m_b = rx_byte;
         if (rx_valid && m_b >= 1 && m_b <= 3) m_set[m_b-1] = 1;
         if (m_act) begin
            if (ack) begin
               m_clr[m_cur-1] = 1;
               m_reps = 0;
            end
            if (m_gap_t >= 0) begin
               if (m_t == m_gap_t + GAP - 1) begin
                  m_act = 0;
                  if (!ack) begin
                     m_reps = (m_reps < MAXR) ? m_reps + 1 : MAXR;
                     if (m_reps == MAXR && m_cur != 1) begin
                        m_clr[m_cur-1] = 1;
                        m_reps = 0;
                     end
                  end
               end
            end else if (m_t > m_req_t) begin
               if (m_seen) begin
                  if (!play_busy) m_gap_t = m_t + 1;
               end else if (play_busy) begin
                  m_seen = 1;
               end else if (m_t - m_req_t >= BTO - 1) begin
                  m_gap_t = m_t + 1;
               end
            end
         end else if (m_pend != 0) begin
            m_b = m_pend[0] ? 1 : (m_pend[1] ? 2 : 3);
            if (m_b != m_cur) m_reps = 0;
            m_cur = m_b;
            m_act = 1; m_seen = 0;
            m_req_t = m_t + 1; m_gap_t = -1;
         end
         m_pend = (m_pend & ~m_clr) | m_set;
         m_t++;
      end
      exp_req   = m_act && (m_t == m_req_t);
      exp_id    = m_act ? m_cur[1:0] : 2'b00;
      exp_alert = m_act;
      exp_pend  = m_pend;
   end

   task automatic do_reset;
      @(negedge clk);
      rst = 1; rx_valid = 0; ack = 0; play_busy = 0; rx_byte = 0;
      @(negedge clk);
      @(negedge clk);
      rst = 0;
   endtask

   task automatic send(input logic [7:0] b);
      @(posedge clk); #1 rx_valid = 1; rx_byte = b;
      @(posedge clk); #1 rx_valid = 0;
   endtask

   task automatic wait_req(input int lim, output int n);
      n = 0;
      while (play_req !== 1'b1 && n < lim) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic test_reset;
      do_reset();
      n_chk++;
      if ({play_req, play_id, alert_active, pending} !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_init: got %b want 0000000",
                  {play_req, play_id, alert_active, pending});
      end
      send(8'h01);
      @(posedge clk);
      @(posedge clk); #3;
      n_chk++;
      if (alert_active !== 1'b1 || pending !== 3'b001) begin
         n_fail++;
         $display("FAIL reset_pre: got alert %b pend %b want 1 001",
                  alert_active, pending);
      end
      rst = 1; #1;
      n_chk++;
      if ({play_req, play_id, alert_active, pending} !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_async: got %b want 0000000",
                  {play_req, play_id, alert_active, pending});
      end
      @(negedge clk);
      @(negedge clk); rst = 0;
      @(negedge clk);
      @(negedge clk);
      n_chk++;
      if (alert_active !== 1'b0 || pending !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_after: got alert %b pend %b want 0 000",
                  alert_active, pending);
      end
   endtask

   task automatic test_doorbell;
      int n;
      do_reset();
      @(posedge clk); #1 rx_valid = 1; rx_byte = 8'h03;
      @(negedge clk);
      n_chk++;
      if (pending !== 3'b000) begin
         n_fail++;
         $display("FAIL db_pend_n: got %b want 000", pending);
      end
      @(posedge clk); #1 rx_valid = 0;
      @(negedge clk);
      n_chk++;
      if (pending !== 3'b100 || play_req !== 1'b0) begin
         n_fail++;
         $display("FAIL db_pend_n1: got pend %b req %b want 100 0",
                  pending, play_req);
      end
      @(negedge clk);
      n_chk++;
      if (play_req !== 1'b1 || play_id !== 2'b11) begin
         n_fail++;
         $display("FAIL db_req_n2: got req %b id %b want 1 11",
                  play_req, play_id);
      end
      for (int p = 1; p <= 3; p++) begin
         @(posedge clk); #1 play_busy = 1;
         @(negedge clk);
         n_chk++;
         if (play_req !== 1'b0) begin
            n_fail++;
            $display("FAIL db_oneshot play %0d: got %b want 0", p, play_req);
         end
         repeat (4) @(posedge clk);
         #1 play_busy = 0;
         @(negedge clk);
         if (p < 3) begin
            wait_req(30, n);
            n_chk++;
            if (n !== 10 || play_id !== 2'b11) begin
               n_fail++;
               $display("FAIL db_replay %0d: got gap %0d id %b want 10 11",
                        p, n, play_id);
            end
         end else begin
            n = 0;
            while (alert_active !== 1'b0 && n < 30) begin
               @(negedge clk);
               n++;
            end
            n_chk++;
            if (n !== 9 || pending !== 3'b000) begin
               n_fail++;
               $display("FAIL db_done: got %0d cyc pend %b want 9 000",
                        n, pending);
            end
         end
      end
   endtask

   task automatic test_preempt;
      int n;
      do_reset();
      send(8'h03);
      @(negedge clk);
      wait_req(10, n);
      @(posedge clk); #1 play_busy = 1;
      @(posedge clk); #1 rx_valid = 1; rx_byte = 8'h01;
      @(posedge clk); #1 rx_valid = 0;
      @(negedge clk);
      n_chk++;
      if (play_id !== 2'b11 || pending !== 3'b101) begin
         n_fail++;
         $display("FAIL pre_noabort: got id %b pend %b want 11 101",
                  play_id, pending);
      end
      @(posedge clk); #1 play_busy = 0;
      @(negedge clk);
      wait_req(30, n);
      n_chk++;
      if (n !== 10 || play_id !== 2'b01 || pending !== 3'b101) begin
         n_fail++;
         $display("FAIL pre_next: got %0d id %b pend %b want 10 01 101",
                  n, play_id, pending);
      end
   endtask

   task automatic test_busy_timeout;
      int n;
      do_reset();
      send(8'h02);
      @(negedge clk);
      wait_req(10, n);
      n_chk++;
      if (play_req !== 1'b1 || play_id !== 2'b10) begin
         n_fail++;
         $display("FAIL to_first: got req %b id %b want 1 10",
                  play_req, play_id);
      end
      @(negedge clk);
      wait_req(40, n);
      n_chk++;
      if (n !== 13 || play_id !== 2'b10) begin
         n_fail++;
         $display("FAIL to_replay: got %0d id %b want 13 10", n, play_id);
      end
   endtask

   task automatic test_smoke_persist;
      int n;
      int plays;
      do_reset();
      send(8'h01);
      @(negedge clk);
      wait_req(10, n);
      for (int p = 2; p <= 5; p++) begin
         @(negedge clk);
         wait_req(40, n);
         n_chk++;
         if (n !== 13 || play_id !== 2'b01 || pending[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL sm_play %0d: got %0d id %b pend %b want 13 01 xx1",
                     p, n, play_id, pending);
         end
      end
      @(posedge clk);
      @(posedge clk); #1 ack = 1;
      @(posedge clk); #1 ack = 0;
      @(negedge clk);
      n_chk++;
      if (pending !== 3'b000 || alert_active !== 1'b1) begin
         n_fail++;
         $display("FAIL sm_ack: got pend %b alert %b want 000 1",
                  pending, alert_active);
      end
      n = 0;
      while (alert_active !== 1'b0 && n < 30) begin
         @(negedge clk);
         n++;
      end
      n_chk++;
      if (n !== 10) begin
         n_fail++;
         $display("FAIL sm_gap_end: got %0d cyc want 10", n);
      end
      plays = 0;
      repeat (20) begin
         @(negedge clk);
         if (play_req === 1'b1) plays++;
      end
      n_chk++;
      if (plays !== 0) begin
         n_fail++;
         $display("FAIL sm_quiet: got %0d plays want 0", plays);
      end
   endtask

   task automatic test_set_over_clear;
      int n;
      int plays;
      do_reset();
      send(8'h02);
      @(negedge clk);
      wait_req(10, n);
      @(negedge clk);
      wait_req(40, n);
      @(posedge clk);
      @(posedge clk); #1 ack = 1; rx_valid = 1; rx_byte = 8'h02;
      @(posedge clk); #1 ack = 0; rx_valid = 0;
      @(negedge clk);
      n_chk++;
      if (pending !== 3'b010) begin
         n_fail++;
         $display("FAIL soc_pend: got %b want 010", pending);
      end
      plays = 0;
      repeat (60) begin
         @(negedge clk);
         if (play_req === 1'b1) begin
            plays++;
            n_chk++;
            if (play_id !== 2'b10) begin
               n_fail++;
               $display("FAIL soc_id: got %b want 10", play_id);
            end
         end
      end
      n_chk++;
      if (plays !== 2 || pending !== 3'b000 || alert_active !== 1'b0) begin
         n_fail++;
         $display("FAIL soc_replays: got %0d pend %b alert %b want 2 000 0",
                  plays, pending, alert_active);
      end
   endtask

   task automatic test_random;
      int bd;
      int bh;
      bd = -1;
      bh = 0;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         rx_valid = ($urandom_range(0, 11) == 0);
         rx_byte  = ($urandom_range(0, 7) == 0) ? 8'($urandom)
                                                 : 8'($urandom_range(0, 5));
         ack      = ($urandom_range(0, 19) == 0);
         if (exp_req) begin
            bd = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(1, 6);
            bh = $urandom_range(1, 6);
            play_busy = 0;
         end else if (bd > 0) begin
            bd--;
            play_busy = 0;
         end else if (bd == 0 && bh > 0) begin
            play_busy = 1;
            bh--;
         end else begin
            play_busy = 0;
         end
         @(negedge clk);
         n_chk++;
         if (play_req !== exp_req) begin
            n_fail++;
            $display("FAIL rnd_req cyc %0d: got %b want %b",
                     i, play_req, exp_req);
         end
         n_chk++;
         if (play_id !== exp_id) begin
            n_fail++;
            $display("FAIL rnd_id cyc %0d: got %b want %b",
                     i, play_id, exp_id);
         end
         n_chk++;
         if (alert_active !== exp_alert) begin
            n_fail++;
            $display("FAIL rnd_alert cyc %0d: got %b want %b",
                     i, alert_active, exp_alert);
         end
         n_chk++;
         if (pending !== exp_pend) begin
            n_fail++;
            $display("FAIL rnd_pend cyc %0d: got %b want %b",
                     i, pending, exp_pend);
         end
      end
      do_reset();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_doorbell();
      test_preempt();
      test_busy_timeout();
      test_smoke_persist();
      test_set_over_clear();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
